// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared matrix geometry, key encoding and priority helper
package key_scan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // Internal key value: MSB set means "no key", low bits are 4*column + row.
  typedef logic [KEY_W:0] key_t;

  localparam key_t KEY_NONE = {1'b1, {KEY_W{1'b0}}};

  // Lowest-numbered pressed key, or KEY_NONE when nothing is pressed.
  function automatic key_t lowest_key(input logic [NUM_KEYS-1:0] pressed);
    key_t k;
    k = KEY_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pressed[i]) k = key_t'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - column dwell counter and column index sequencer
module scan_timer
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [COL_W-1:0] col_idx,
  output logic             last_dwell
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] dwell_cnt;

  assign last_dwell = (dwell_cnt == DWELL_MAX);

  // Count the dwell and step to the next column on its final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
    end else if (last_dwell) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 1'b1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - 4x4 key matrix scan, debounce and press/release events
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_release,
  input  logic                key_ready,
  output logic                key_down
);

  localparam logic [3:0]       DEB_MAX  = 4'(DEB_SCANS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam int               SNAP_W   = (NUM_COLS - 1) * NUM_ROWS;

  logic [COL_W-1:0]    col_idx;
  logic                last_dwell;
  logic                scan_end;
  logic [NUM_ROWS-1:0] row_s1;
  logic [NUM_ROWS-1:0] row_s2;
  logic [SNAP_W-1:0]   row_snap;
  logic [NUM_KEYS-1:0] scan_rows;
  key_t                candidate;
  key_t                prev_cand;
  key_t                committed;
  logic [3:0]          stable_cnt;
  logic [3:0]          stable_next;
  logic                commit;

  scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_idx    (col_idx),
    .last_dwell (last_dwell)
  );

  assign col_out  = ~(NUM_COLS'(1) << col_idx);
  assign scan_end = last_dwell && (col_idx == LAST_COL);
  assign key_down = ~committed[KEY_W];

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // Capture rows at the end of each dwell for every column but the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_snap <= '1;
    end else if (last_dwell && (col_idx != LAST_COL)) begin
      row_snap[col_idx*NUM_ROWS +: NUM_ROWS] <= row_s2;
    end
  end

  // Full scan image; the last column is taken live on its sample cycle.
  always_comb begin
    scan_rows = {row_s2, row_snap};
    candidate = lowest_key(~scan_rows);
  end

  // Stable count for this scan and the commit decision.
  always_comb begin
    stable_next = 4'd1;
    if (candidate == prev_cand) begin
      stable_next = (stable_cnt >= DEB_MAX) ? DEB_MAX : stable_cnt + 4'd1;
    end
    commit = scan_end && (stable_next == DEB_MAX) &&
             (candidate != committed) && !key_valid;
  end

  // Debounce history, updated once per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand  <= KEY_NONE;
      stable_cnt <= 4'd0;
    end else if (scan_end) begin
      prev_cand  <= candidate;
      stable_cnt <= stable_next;
    end
  end

  // Event register: a held key is always released before a new one is pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_release <= 1'b0;
      committed   <= KEY_NONE;
    end else if (commit) begin
      key_valid <= 1'b1;
      if (!committed[KEY_W]) begin
        key_code    <= committed[KEY_W-1:0];
        key_release <= 1'b1;
        committed   <= KEY_NONE;
      end else begin
        key_code    <= candidate[KEY_W-1:0];
        key_release <= 1'b0;
        committed   <= candidate;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - scan-level model plus directed key scenarios
module tb_key_matrix_scanner;

  localparam int SD      = 4;
  localparam int DEB     = 3;
  localparam int SCAN    = 4 * SD;
  localparam int NONE_ID = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ready = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic        key_down;
  logic [15:0] mask = 16'h0;

  int total = 0;
  int bad = 0;

  int m_edges = 0;
  int m_prev = NONE_ID;
  int m_stable = 0;
  int m_committed = NONE_ID;
  bit m_valid = 1'b0;
  int m_code = 0;
  int m_rel = 0;

  int ev_q[$];

  key_matrix_scanner #(
    .SCAN_DIV  (SD),
    .DEB_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .key_ready   (key_ready),
    .key_down    (key_down)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_out[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (mask[4*c + r]) row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return NONE_ID;
  endfunction

  // Scan-level model: every 16th edge is a scan end judged on the held mask.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_edges = 0; m_prev = NONE_ID; m_stable = 0; m_committed = NONE_ID;
        m_valid = 1'b0; m_code = 0; m_rel = 0;
      end else begin
        automatic bit accept = m_valid && key_ready;
        m_edges++;
        if (m_edges % SCAN == 0) begin
          automatic int cand = lowest(mask);
          m_stable = (cand == m_prev) ? ((m_stable + 1 > DEB) ? DEB : m_stable + 1) : 1;
          m_prev = cand;
          if (m_stable == DEB && cand != m_committed && !m_valid) begin
            if (m_committed != NONE_ID) begin
              m_code = m_committed; m_rel = 1; m_committed = NONE_ID;
            end else begin
              m_code = cand; m_rel = 0; m_committed = cand;
            end
            m_valid = 1'b1;
            accept = 1'b0;
          end
        end
        if (accept) m_valid = 1'b0;
      end
    end
  end

  // Accepted events, encoded as 16*release + code.
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) ev_q.push_back(16 * int'(key_release) + int'(key_code));
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic [3:0] exp_col = ~(4'b0001 << ((m_edges / SD) % 4));
      check("col_out", int'(col_out), int'(exp_col));
      check("key_valid", int'(key_valid), int'(m_valid));
      check("key_down", int'(key_down), int'(m_committed != NONE_ID));
      if (m_valid) begin
        check("key_code", int'(key_code), m_code);
        check("key_release", int'(key_release), m_rel);
      end
    end
  end

  task automatic do_reset(input logic [15:0] m);
    rst_n = 1'b0;
    mask = m;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  initial begin
    // Idle matrix: columns rotate, nothing is reported.
    do_reset(16'h0);
    ev_q.delete();
    for (int i = 0; i < 8; i++) begin
      automatic logic [3:0] e = ~(4'b0001 << (i % 4));
      check("idle_col_seq", int'(col_out), int'(e));
      repeat (SD) @(negedge clk);
    end
    check("idle_events", ev_q.size(), 0);

    // Key 6 held from reset: press appears right after the third scan end.
    do_reset(16'h0040);
    ev_q.delete();
    repeat (3 * SCAN - 1) @(negedge clk);
    check("k6_not_yet", int'(key_valid), 0);
    @(negedge clk);
    check("k6_valid", int'(key_valid), 1);
    check("k6_code", int'(key_code), 6);
    check("k6_release", int'(key_release), 0);
    check("k6_down", int'(key_down), 1);
    run_scans(2);
    check("k6_events", ev_q.size(), 1);
    if (ev_q.size() >= 1) check("k6_ev0", ev_q[0], 6);

    // Bounce shorter than the debounce window, then a clean release.
    mask = 16'h0000; run_scans(1);
    mask = 16'h0040; run_scans(1);
    mask = 16'h0000; run_scans(1);
    mask = 16'h0040; run_scans(1);
    mask = 16'h0000; run_scans(4);
    check("bounce_events", ev_q.size(), 2);
    if (ev_q.size() >= 2) check("bounce_ev1", ev_q[1], 16 + 6);
    check("bounce_down", int'(key_down), 0);

    // Keys 9 and 2 together: only the lower code is pressed.
    do_reset(16'h0204);
    ev_q.delete();
    run_scans(5);
    check("two_events", ev_q.size(), 1);
    if (ev_q.size() >= 1) check("two_ev0", ev_q[0], 2);
    check("two_down", int'(key_down), 1);

    // Switch 2 -> 9 with the consumer stalled for 20 scans.
    key_ready = 1'b0;
    mask = 16'h0200;
    run_scans(20);
    check("stall_valid", int'(key_valid), 1);
    check("stall_code", int'(key_code), 2);
    check("stall_release", int'(key_release), 1);
    check("stall_events", ev_q.size(), 1);
    key_ready = 1'b1;
    run_scans(3);
    check("switch_events", ev_q.size(), 3);
    if (ev_q.size() >= 3) begin
      check("switch_ev1", ev_q[1], 16 + 2);
      check("switch_ev2", ev_q[2], 9);
    end
    check("switch_down", int'(key_down), 1);

    // Asynchronous reset while an event is pending discards it.
    do_reset(16'h0040);
    ev_q.delete();
    key_ready = 1'b0;
    run_scans(4);
    check("pend_valid", int'(key_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(key_valid), 0);
    check("arst_col", int'(col_out), 14);
    check("arst_down", int'(key_down), 0);
    key_ready = 1'b1;
    mask = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scans(4);
    check("arst_events", ev_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles each column is driven (dwell); legal range >= 4.
REQ-002 Parameter DEB_SCANS, default 4: consecutive full scans with identical candidate before commit; legal range 1..15.
REQ-003 Port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port row_in, input, 4: matrix rows; asynchronous, pulled up, 0 = contact closed.
REQ-006 Port col_out, output, 4: column drive; active-low one-hot, exactly one bit 0 at all times after reset.
REQ-007 Port key_valid, output, 1: event pending.
REQ-008 Port key_code, output, 4: event key index = 4*column + row.
REQ-009 Port key_release, output, 1: event type; 0 = press, 1 = release.
REQ-010 Port key_ready, input, 1: consumer accepts event when high with key_valid high at a rising edge.
REQ-011 Port key_down, output, 1: level; 1 while a committed key is held.

Function
REQ-012 Column index shall advance 0,1,2,3,0,... every SCAN_DIV cycles; col_out = ~(1 << index).
REQ-013 row_in shall pass through a two-flop synchronizer before any use.
REQ-014 Synchronized rows shall be sampled on the last cycle of each column dwell only.
REQ-015 After the column-3 sample, the scan's candidate shall be the lowest pressed key code, or NONE if no row reads 0.
REQ-016 Stable count shall increment, saturating at DEB_SCANS, when candidate equals previous scan's candidate; otherwise reset to 1.
REQ-017 A commit shall occur at scan end when stable count = DEB_SCANS, candidate differs from committed key, and key_valid is 0.
REQ-018 Commit from committed K (not NONE) to any different value: emit release of K; committed becomes NONE.
REQ-019 Commit from NONE to key J: emit press of J; committed becomes J.
REQ-020 K to J therefore yields release K, then press J on a later eligible scan end; never both in one scan.
REQ-021 Emission: key_valid rises the cycle after scan end; key_code and key_release held constant while key_valid = 1.
REQ-022 key_valid shall clear the cycle after acceptance; simultaneous scan-end commit is blocked by REQ-017, so no event is lost or overwritten.
REQ-023 While key_valid = 1 and key_ready = 0, commits stall; scanning and debouncing continue.
REQ-024 key_down shall equal (committed != NONE), updated with the commit.
REQ-025 Arithmetic: dwell counter ceil(log2(SCAN_DIV)) bits, wraps at SCAN_DIV-1; stable counter 4 bits, saturating.

Reset
REQ-026 On rst_n low, immediately: col_out = 4'b1110, column index 0, dwell counter 0, synchronizer flops 1.
REQ-027 On rst_n low: key_valid 0, key_code 0, key_release 0, key_down 0, committed NONE, previous candidate NONE, stable count 0.
REQ-028 Reset mid-event discards any pending event; scanning restarts at column 0 on the first edge after rst_n rises.

Structure
REQ-029 Shared package key_scan_pkg shall hold NUM_ROWS = 4, NUM_COLS = 4, KEY_W = 4, and the NONE sentinel (5-bit internal encoding, MSB set).
REQ-030 One sub-module, scan_timer, shall contain the dwell counter and column index and output a last_dwell strobe and the index.
REQ-031 Candidate selection, debounce and event handshake shall remain in key_matrix_scanner.

Verification (SCAN_DIV = 4, DEB_SCANS = 3)
REQ-032 Reset release, rows all 1 -> col_out cycles 1110, 1101, 1011, 0111 every 4 clk; key_valid never rises.
REQ-033 Hold key 6 (column 1, row 2) -> exactly one event: code 6, release 0, on the third scan end, with key_down = 1.
REQ-034 Key 6 held, bounce lasting under 3 scans, then release -> no extra press; one release event with code 6 after 3 clean scans.
REQ-035 Keys 9 and 2 pressed together -> press code 2 only.
REQ-036 Key 2 held, switch to key 9 with key_ready = 0 for 20 scans -> release 2 held stable until accepted; press 9 follows on a later scan end.
REQ-037 rst_n pulsed low while key_valid = 1 -> key_valid = 0 and col_out = 1110 asynchronously; the pending event is never delivered.
